// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared definitions for the seven-segment control peripheral:
//                register offsets, CTRL bit positions and the CTRL struct.
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

    // Register byte offsets. Only addr[3:2] is decoded.
    localparam logic [3:0] SEG_DATA     = 4'h0;
    localparam logic [3:0] SEG_CTRL     = 4'h4;
    localparam logic [3:0] SEG_PRESCALE = 4'h8;
    localparam logic [3:0] SEG_STATUS   = 4'hC;

    // CTRL bit positions
    localparam int c_ctrl_count_en = 0;
    localparam int c_ctrl_freeze   = 1;
    localparam int c_ctrl_down     = 2;

    // Packed so that count_en lands on bit 0 and down on bit 2
    typedef struct packed {
        logic down;
        logic freeze;
        logic count_en;
    } seg_ctrl_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : seg_prescaler
//  Description : Programmable tick generator. Counts 0..P-1 with
//                P = max(period, 1) and pulses tick for one cycle on the
//                last count. Held at 0 while disabled or restarted.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en            - count enable
//                period[31:0]  - cycles per tick (0 behaves as 1)
//                restart       - force the count back to 0 this edge
//                tick          - single-cycle output pulse
//  Revision    : 1.0  initial release
// ============================================================================
module seg_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] period,
    input  logic        restart,
    output logic        tick
);

    logic [31:0] r_count;
    logic [31:0] w_last;
    logic        w_at_last;

    // period 0 collapses to a terminal count of 0, giving a tick every cycle
    assign w_last    = (period == 32'd0) ? 32'd0 : period - 32'd1;
    // >= keeps the counter bounded if the period were ever below the count
    assign w_at_last = (r_count >= w_last);
    assign tick      = en & ~rst & ~restart & w_at_last;

    always_ff @(posedge clk) begin
        if (rst || !en || restart || w_at_last) begin
            r_count <= 32'd0;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

endmodule : seg_prescaler
`default_nettype wire

// File: rtl/seg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_ctrl
//  Description : Memory-mapped control peripheral producing the 16-bit value
//                for the four-digit seven-segment driver. Holds a software
//                value, supports a freeze shadow and a prescaled up/down
//                self-test count that wraps within 0..MAX_VALUE.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                sel, we          - bus access strobe / write select
//                addr[3:0]        - byte address, addr[3:2] picks register
//                wdata[31:0]      - write data
//                wstrb[3:0]       - byte write enables
//                rdata[31:0]      - registered read data
//                rvalid           - one-cycle read-data-valid pulse
//                data_seg[15:0]   - registered value to display driver
//  Revision    : 1.0  initial release
// ============================================================================
module seg_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PRESCALE = 32'd100_000_000,
    parameter int          MAX_VALUE        = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [15:0] data_seg
);

    localparam logic [15:0] c_max_value = MAX_VALUE[15:0];

    logic [15:0] r_value;
    seg_ctrl_t   r_ctrl;
    logic [31:0] r_prescale;
    logic        r_wrap;
    logic [15:0] r_shadow;
    logic [15:0] r_data_seg;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    logic        w_wr;
    logic        w_rd;
    logic        w_wr_data;
    logic        w_wr_ctrl;
    logic        w_wr_prescale;
    logic        w_wr_status;
    logic        w_wrap_clear;
    logic        w_freeze_rise;
    logic        w_tick;
    logic [15:0] w_value_next;
    logic        w_wrap_set;
    logic [31:0] w_rdata_next;

    assign w_wr = sel & we;
    assign w_rd = sel & ~we;

    // A DATA write with no strobes on the low two bytes touches nothing,
    // so it neither discards a tick nor restarts the prescaler.
    assign w_wr_data     = w_wr & (addr[3:2] == SEG_DATA[3:2]) & (|wstrb[1:0]);
    assign w_wr_ctrl     = w_wr & (addr[3:2] == SEG_CTRL[3:2]) & wstrb[0];
    assign w_wr_prescale = w_wr & (addr[3:2] == SEG_PRESCALE[3:2]) & (|wstrb);
    assign w_wr_status   = w_wr & (addr[3:2] == SEG_STATUS[3:2]);
    assign w_wrap_clear  = w_wr_status & wstrb[0] & wdata[0];
    assign w_freeze_rise = w_wr_ctrl & wdata[c_ctrl_freeze] & ~r_ctrl.freeze;

    seg_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (r_ctrl.count_en),
        .period  (r_prescale),
        .restart (w_wr_data | w_wr_prescale),
        .tick    (w_tick)
    );

    // Software writes take priority over a coincident tick
    always_comb begin
        w_value_next = r_value;
        w_wrap_set   = 1'b0;
        if (w_wr_data) begin
            if (wstrb[0]) w_value_next[7:0]  = wdata[7:0];
            if (wstrb[1]) w_value_next[15:8] = wdata[15:8];
        end else if (w_tick) begin
            if (!r_ctrl.down) begin
                if (r_value >= c_max_value) begin
                    w_value_next = 16'd0;
                    w_wrap_set   = 1'b1;
                end else begin
                    w_value_next = r_value + 16'd1;
                end
            end else begin
                if (r_value == 16'd0) begin
                    w_value_next = c_max_value;
                    w_wrap_set   = 1'b1;
                end else begin
                    w_value_next = r_value - 16'd1;
                end
            end
        end
    end

    // Read mux sees only current register contents (pre-update)
    always_comb begin
        w_rdata_next = 32'd0;
        case (addr[3:2])
            SEG_DATA[3:2]:     w_rdata_next = {16'h0, r_value};
            SEG_CTRL[3:2]:     w_rdata_next = {29'h0, r_ctrl};
            SEG_PRESCALE[3:2]: w_rdata_next = r_prescale;
            default:           w_rdata_next = {31'h0, r_wrap};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value    <= 16'd0;
            r_ctrl     <= '0;
            r_prescale <= DEFAULT_PRESCALE;
            r_wrap     <= 1'b0;
            r_shadow   <= 16'd0;
            r_data_seg <= 16'd0;
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
        end else begin
            r_value <= w_value_next;

            if (w_wr_ctrl) begin
                r_ctrl <= seg_ctrl_t'(wdata[2:0]);
            end

            for (int i = 0; i < 4; i++) begin
                if (w_wr_prescale && wstrb[i]) begin
                    r_prescale[i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end

            // Set dominates clear when both land on the same edge
            r_wrap <= w_wrap_set | (r_wrap & ~w_wrap_clear);

            // Capture the value as it stood before any same-cycle DATA write
            if (w_freeze_rise) begin
                r_shadow <= r_value;
            end

            r_data_seg <= r_ctrl.freeze ? r_shadow : r_value;

            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign data_seg = r_data_seg;

endmodule : seg_ctrl
`default_nettype wire

// File: tb/tb_seg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_ctrl
//  Description : Directed self-checking bench for seg_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_ctrl;

    localparam logic [31:0] c_def_pre = 32'd100_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic [15:0] data_seg;

    int n_total = 0;
    int n_pass  = 0;

    seg_ctrl #(
        .DEFAULT_PRESCALE (c_def_pre),
        .MAX_VALUE        (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .data_seg (data_seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change on falling edges; task returns at the falling edge
    // after the write edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d; wstrb = s;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, input string tag, input logic [31:0] exp);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        check({tag, "_rvalid"}, {31'h0, rvalid}, 32'h1);
        check(tag, rdata, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_data_seg", {16'h0, data_seg}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        rd(4'h0, "rst_data", 32'h0);
        rd(4'h4, "rst_ctrl", 32'h0);
        rd(4'h8, "rst_prescale", c_def_pre);
        rd(4'hC, "rst_status", 32'h0);
        @(negedge clk);
        check("rvalid_idle", {31'h0, rvalid}, 32'h0);

        // Byte strobes
        wr(4'h0, 32'h0000_1234, 4'b0001);
        rd(4'h0, "data_lo_byte", 32'h0000_0034);
        wr(4'h0, 32'h0000_1234, 4'b0011);
        check("data_seg_1edge", {16'h0, data_seg}, 32'h0000_0034);
        @(negedge clk);
        check("data_seg_2edge", {16'h0, data_seg}, 32'h0000_1234);
        wr(4'h0, 32'hFFFF_FFFF, 4'b1100);
        rd(4'h0, "data_unused_bytes", 32'h0000_1234);
        wr(4'h8, 32'hAABB_CCDD, 4'b0101);
        rd(4'h8, "prescale_bytes", 32'h05BB_E1DD);

        // Up count, PRESCALE=3, wrap 9999 -> 0
        wr(4'h8, 32'd3, 4'hF);
        wr(4'h0, 32'd9998, 4'hF);
        wr(4'h4, 32'h1, 4'h1);
        repeat (2) @(negedge clk);
        check("up_before_tick", {16'h0, data_seg}, 32'd9998);
        repeat (2) @(negedge clk);
        check("up_9999", {16'h0, data_seg}, 32'd9999);
        repeat (3) @(negedge clk);
        check("up_wrap_0", {16'h0, data_seg}, 32'd0);
        rd(4'hC, "up_wrap_status", 32'h1);
        wr(4'hC, 32'h1, 4'h1);
        rd(4'hC, "status_cleared", 32'h0);
        wr(4'h4, 32'h0, 4'h1);

        // Down count, PRESCALE=0 -> tick every cycle
        wr(4'h8, 32'd0, 4'hF);
        wr(4'h0, 32'd1, 4'h3);
        wr(4'h4, 32'h5, 4'h1);
        sel = 1'b1; we = 1'b0; addr = 4'h0;
        @(negedge clk);
        check("down_rd_1", rdata, 32'd1);
        // Clear STATUS in the same cycle the 0 -> 9999 wrap happens
        we = 1'b1; addr = 4'hC; wdata = 32'h1; wstrb = 4'h1;
        @(negedge clk);
        check("down_seg_0", {16'h0, data_seg}, 32'd0);
        we = 1'b0; addr = 4'h0; wstrb = 4'h0;
        @(negedge clk);
        check("down_rd_9999", rdata, 32'd9999);
        check("down_seg_9999", {16'h0, data_seg}, 32'd9999);
        addr = 4'hC;
        @(negedge clk);
        check("wrap_set_beats_clear", rdata, 32'h1);
        addr = 4'h4;
        @(negedge clk);
        check("ctrl_readback", rdata, 32'h5);
        sel = 1'b0;
        wr(4'h4, 32'h0, 4'h1);
        wr(4'hC, 32'h1, 4'h1);
        rd(4'hC, "status_cleared2", 32'h0);

        // Freeze
        wr(4'h0, 32'd42, 4'h3);
        wr(4'h4, 32'h2, 4'h1);
        wr(4'h0, 32'd7, 4'h3);
        @(negedge clk);
        check("freeze_hold", {16'h0, data_seg}, 32'd42);
        rd(4'h0, "freeze_data_rd", 32'd7);
        wr(4'h4, 32'h0, 4'h1);
        @(negedge clk);
        check("unfreeze", {16'h0, data_seg}, 32'd7);

        // DATA write on a tick cycle, PRESCALE=3
        wr(4'h8, 32'd3, 4'hF);
        wr(4'h0, 32'd100, 4'h3);
        wr(4'h4, 32'h1, 4'h1);
        @(negedge clk);
        wr(4'h0, 32'd500, 4'h3);
        @(negedge clk);
        check("wr_vs_tick", {16'h0, data_seg}, 32'd500);
        repeat (2) @(negedge clk);
        check("wr_vs_tick_hold", {16'h0, data_seg}, 32'd500);
        @(negedge clk);
        check("after_restart_tick", {16'h0, data_seg}, 32'd501);

        // Reset mid-count
        rd(4'h0, "pre_reset_rd", 32'd501);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("mid_rst_seg", {16'h0, data_seg}, 32'h0);
        repeat (5) @(negedge clk);
        check("post_rst_no_count", {16'h0, data_seg}, 32'h0);
        rd(4'h0, "post_rst_data", 32'h0);
        rd(4'h4, "post_rst_ctrl", 32'h0);
        rd(4'h8, "post_rst_prescale", c_def_pre);
        rd(4'hC, "post_rst_status", 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seg_ctrl
`default_nettype wire

// File: doc/seg_ctrl.md
# seg_ctrl

Memory-mapped control peripheral that produces the 16-bit `data_seg` value consumed by the four-digit seven-segment display driver. It sits between the CPU data bus and the display driver. It holds a software-written display value and supports a freeze (hold) mode. It also has a self-test count mode that steps the value up or down through 0..9999 at a programmable prescaled rate.

## Interface
- `DEFAULT_PRESCALE`, default 100_000_000: reset value of the PRESCALE register, in clk cycles per count tick.
- `MAX_VALUE`, default 9999: wrap limit for count mode.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high. The clock is `clk`.
- `sel` in, 1: bus access this cycle.
- `we` in, 1: 1 = write, 0 = read. Qualified by `sel`.
- `addr` in, 4: byte address. `addr[3:2]` selects the register; `addr[1:0]` is ignored.
- `wdata` in, 32: write data.
- `wstrb` in, 4: byte write enables.
- `rdata` out, 32: read data, registered.
- `rvalid` out, 1: one-cycle pulse, `rdata` valid.
- `data_seg` out, 16: value to the display driver, registered.

## Operation
Register map:
- 0x0 DATA, RW, bits [15:0].
  - Write honours `wstrb[1:0]` only.
  - Read returns {16'h0, value}.
- 0x4 CTRL, RW, bits [2:0].
  - bit0 `count_en`, bit1 `freeze`, bit2 `down`.
  - Written when `wstrb[0]`=1.
- 0x8 PRESCALE, RW, 32 bits.
  - Each byte is written per its `wstrb` bit.
  - A write restarts the prescaler count at 0.
  - A value of 0 behaves as 1 (one tick every cycle).
- 0xC STATUS, bit0 `wrap`, sticky.
  - Set on any count wrap.
  - Cleared by a write with `wdata[0]`=1 and `wstrb[0]`=1. Other bits read 0.

Count mode (`count_en`=1):
- The prescaler counts 0..P-1, where P = max(PRESCALE, 1). `tick` pulses for one cycle when the count reaches P-1, then the count returns to 0.
- Up (`down`=0) on tick: if value >= MAX_VALUE then value <= 0 and set `wrap`; else value <= value+1.
- Down (`down`=1) on tick: if value == 0 then value <= MAX_VALUE and set `wrap`; else value <= value-1.
- When `count_en`=0, the prescaler is held at 0 and no ticks occur.

Freeze:
- On the rising edge of `freeze` (CTRL write changes it 0->1), the current value is captured into a shadow register.
- While `freeze`=1, `data_seg` = shadow. DATA writes and counting still update the value.
- When `freeze` returns to 0, `data_seg` follows the value again.

Simultaneous events:
- A DATA write in the same cycle as a tick: the write wins, the tick is discarded, and the prescaler restarts at 0.
- A STATUS clear in the same cycle as a wrap: the set wins, so `wrap` stays 1.
- A CTRL write setting `freeze` in the same cycle as a DATA write: the shadow captures the pre-write value.

Reads and unused bytes:
- A read of any address returns the register contents from before any same-cycle update.
- Writes with `wstrb` bits for unused bytes have no effect.

## Timing
- Reset values:
  - value = 0, CTRL = 0, PRESCALE = DEFAULT_PRESCALE, `wrap` = 0, shadow = 0.
  - prescaler count = 0, `data_seg` = 0, `rdata` = 0, `rvalid` = 0.
- Write latency: a register updates at the clock edge ending the `sel`&`we` cycle. `data_seg` reflects it one cycle later.
- Read latency: `rdata` and `rvalid` are valid in the cycle after the `sel`&!`we` cycle. `rvalid` is low otherwise. `rdata` holds its value until the next read.
- Back-to-back accesses are accepted every cycle. There is no stall and no error response.
- Tick to `data_seg` change: value updates on the tick edge, and `data_seg` follows one cycle later.
- Reset mid-count: all state returns to reset values on the next edge. No tick is generated in the reset cycle.

## Structure
- Package `seg_pkg`:
  - register offset constants `SEG_DATA`, `SEG_CTRL`, `SEG_PRESCALE`, `SEG_STATUS`;
  - CTRL bit index constants;
  - a packed struct `seg_ctrl_t {down, freeze, count_en}`.
- Sub-module `seg_prescaler`:
  - inputs: `clk`, `rst`, `en`, `period[31:0]`, `restart`;
  - output: single-cycle `tick`;
  - implements the 0-as-1 rule.
- Top level holds the register file, the count/wrap arithmetic, freeze shadow, the read mux, and the output register.

## Test plan
- Reset, then read all four registers -> rdata 0, 0, DEFAULT_PRESCALE, 0; `data_seg`=0.
- Write DATA=0x1234 with wstrb=4'b0001 -> value 0x0034. Then write with wstrb=4'b0011 and wdata 0x1234 -> `data_seg`=0x1234 two edges after the write cycle.
- PRESCALE=3, DATA=9998, CTRL=count_en -> ticks every 3 cycles; value 9999 -> 0 with STATUS.wrap=1. Clear STATUS -> reads 0 unless a wrap occurs in the same cycle.
- PRESCALE=0, CTRL=count_en|down, DATA=1 -> value 0 then 9999 on consecutive cycles, with wrap set.
- DATA=42, set freeze, write DATA=7 -> `data_seg` stays 42 and DATA reads 7. Clear freeze -> `data_seg`=7.
- DATA write coinciding with a tick, and `rst` asserted mid-count -> the written value is kept with no increment; after reset all outputs equal their reset values.
